reg_bank: RTL and testbench



---
 rtl/reg_bank.sv | 61 ++++++
 tb/tb_reg_bank.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/reg_bank.sv
// General-purpose register file: 2**ADDR_W words, r0 hardwired to zero,
// two combinational read ports with write-through bypass, one synchronous write port.
module reg_bank #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] RA1,
  input  logic [ADDR_W-1:0] RA2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  input  logic [ADDR_W-1:0] WA,
  input  logic [DATA_W-1:0] WD,
  input  logic              RegWrite
);

  localparam int NREG  = 2 ** ADDR_W;
  localparam int NPORT = 2;

  logic [NREG-1:0][DATA_W-1:0]  mem_q, mem_d;
  logic [NPORT-1:0][ADDR_W-1:0] ra;
  logic [NPORT-1:0][DATA_W-1:0] rd;
  logic                         wr_en;

  // Reset wins over a same-cycle write; r0 is never written so it stays zero.
  assign wr_en = rst_n && RegWrite && (WA != '0);

  always_comb begin
    mem_d = mem_q;
    if (!rst_n) begin
      mem_d = '0;
    end else if (wr_en) begin
      mem_d[WA] = WD;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign ra[0] = RA1;
  assign ra[1] = RA2;

  // Bypass hands a same-cycle consumer the value about to be written.
  always_comb begin
    rd = '0;
    for (int p = 0; p < NPORT; p++) begin
      if (ra[p] == '0)
        rd[p] = '0;
      else if (wr_en && (WA == ra[p]))
        rd[p] = WD;
      else
        rd[p] = mem_q[ra[p]];
    end
  end

  assign RD1 = rd[0];
  assign RD2 = rd[1];

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: directed scenarios plus randomized traffic
// checked against an array-based reference model.
module tb_reg_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  ra1, ra2, wa;
  logic [31:0] rd1, rd2, wd;
  logic        we;

  logic [31:0] model [32];
  int n_checks = 0;
  int n_fail   = 0;

  reg_bank #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .RA1(ra1), .RA2(ra2), .RD1(rd1), .RD2(rd2),
    .WA(wa), .WD(wd), .RegWrite(we)
  );

  always #5 clk = ~clk;

  // Reference: what a reader should see right now, given stored state and the driven write.
  function automatic logic [31:0] exp_rd(input logic [4:0] ra);
    if (ra == 5'd0) return 32'h0;
    if (rst_n && we && wa == ra) return wd;
    return model[ra];
  endfunction

  // Advance one rising edge, updating the model by the architectural rules.
  task automatic edge_step();
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (we && wa != 5'd0) begin
      model[wa] = wd;
    end
    #1;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; wa = a; wd = d;
    edge_step();
    we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;
    edge_step();
    for (int i = 0; i < 32; i++) begin
      ra1 = i[4:0]; ra2 = 5'(31 - i); #1;
      n_checks++;
      if (rd1 !== 32'h0) begin n_fail++; $display("FAIL reset_rd1[%0d]: got %h want 00000000", i, rd1); end
      n_checks++;
      if (rd2 !== 32'h0) begin n_fail++; $display("FAIL reset_rd2[%0d]: got %h want 00000000", 31 - i, rd2); end
    end
    rst_n = 1'b1;
    do_write(5'd5, 32'hDEADBEEF);
    ra1 = 5'd5; #1;
    n_checks++;
    if (rd1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL preload_r5: got %h want deadbeef", rd1); end
    rst_n = 1'b0;
    edge_step();
    rst_n = 1'b1;
    ra1 = 5'd5; ra2 = 5'd31; #1;
    n_checks++;
    if (rd1 !== 32'h0) begin n_fail++; $display("FAIL reset_clear_r5: got %h want 00000000", rd1); end
    n_checks++;
    if (rd2 !== 32'h0) begin n_fail++; $display("FAIL reset_clear_r31: got %h want 00000000", rd2); end
  endtask

  task automatic test_write_read();
    do_write(5'd7, 32'h12345678);
    ra1 = 5'd7; ra2 = 5'd8; #1;
    n_checks++;
    if (rd1 !== 32'h12345678) begin n_fail++; $display("FAIL write_read_r7: got %h want 12345678", rd1); end
    n_checks++;
    if (rd2 !== 32'h0) begin n_fail++; $display("FAIL write_read_r8: got %h want 00000000", rd2); end
  endtask

  task automatic test_reg_zero();
    ra1 = 5'd0; ra2 = 5'd0;
    we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; #1;
    n_checks++;
    if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
      n_fail++; $display("FAIL r0_during: got %h/%h want 0/0", rd1, rd2);
    end
    edge_step();
    we = 1'b0; #1;
    n_checks++;
    if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
      n_fail++; $display("FAIL r0_after: got %h/%h want 0/0", rd1, rd2);
    end
  endtask

  task automatic test_bypass();
    do_write(5'd3, 32'h00000011);
    ra1 = 5'd3; ra2 = 5'd3;
    we = 1'b1; wa = 5'd3; wd = 32'h00000022; #1;
    n_checks++;
    if (rd1 !== 32'h22) begin n_fail++; $display("FAIL bypass_rd1_before: got %h want 00000022", rd1); end
    n_checks++;
    if (rd2 !== 32'h22) begin n_fail++; $display("FAIL bypass_rd2_before: got %h want 00000022", rd2); end
    edge_step();
    n_checks++;
    if (rd1 !== 32'h22) begin n_fail++; $display("FAIL bypass_after: got %h want 00000022", rd1); end
    we = 1'b0; wd = 32'h99; #1;
    n_checks++;
    if (rd1 !== 32'h22 || rd2 !== 32'h22) begin
      n_fail++; $display("FAIL bypass_we0: got %h/%h want 00000022", rd1, rd2);
    end
    edge_step();
    n_checks++;
    if (rd1 !== 32'h22) begin n_fail++; $display("FAIL bypass_we0_edge: got %h want 00000022", rd1); end
  endtask

  task automatic test_reset_collision();
    do_write(5'd9, 32'hAAAA5555);
    rst_n = 1'b0; we = 1'b1; wa = 5'd9; wd = 32'h1; ra1 = 5'd9; #1;
    n_checks++;
    if (rd1 !== 32'hAAAA5555) begin n_fail++; $display("FAIL collide_before: got %h want aaaa5555", rd1); end
    edge_step();
    n_checks++;
    if (rd1 !== 32'h0) begin n_fail++; $display("FAIL collide_after: got %h want 00000000", rd1); end
    rst_n = 1'b1; we = 1'b0;
    edge_step();
    n_checks++;
    if (rd1 !== 32'h0) begin n_fail++; $display("FAIL collide_released: got %h want 00000000", rd1); end
  endtask

  task automatic test_alu_hookup();
    logic [31:0] res;
    do_write(5'd1, 32'h5);
    do_write(5'd2, 32'h3);
    ra1 = 5'd1; ra2 = 5'd2; #1;
    res = rd1 - rd2;  // ALUSel=001: subtract
    n_checks++;
    if (res !== 32'h2 || res == 32'h0) begin n_fail++; $display("FAIL alu_res: got %h want 00000002 Z=0", res); end
    do_write(5'd4, res);
    ra1 = 5'd4; #1;
    n_checks++;
    if (rd1 !== 32'h2) begin n_fail++; $display("FAIL alu_writeback: got %h want 00000002", rd1); end
  endtask

  task automatic test_random();
    logic [31:0] e1, e2;
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 24) != 0);
      we    = $urandom_range(0, 1);
      wa    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      ra1   = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom);
      ra2   = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom);
      wd    = $urandom;
      #1;
      e1 = exp_rd(ra1); e2 = exp_rd(ra2);
      n_checks++;
      if (rd1 !== e1) begin n_fail++; $display("FAIL rand_rd1[%0d]: RA1=%0d got %h want %h", n, ra1, rd1, e1); end
      n_checks++;
      if (rd2 !== e2) begin n_fail++; $display("FAIL rand_rd2[%0d]: RA2=%0d got %h want %h", n, ra2, rd2, e2); end
      edge_step();
    end
    rst_n = 1'b1; we = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    rst_n = 1'b0; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;
    #2;
    test_reset();
    test_write_read();
    test_reg_zero();
    test_bypass();
    test_reset_collision();
    test_alu_hookup();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
